// File: rtl/arm_pkg.sv
// Shared definitions for the SRAM bridge: FSM state encoding and default
// mapping/timing constants.
package arm_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } sram_state_t;

    localparam int SRAM_BASE_ADDR      = 1024;
    localparam int SRAM_ACCESS_CYCLES  = 2;
    localparam int SRAM_DQ_WIDTH       = 16;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage side of the SRAM bridge: word request in, load data and
// pipeline-freeze (ready) out.
interface sram_controller_if #(
    parameter int BIT_NUMBER = 32
);

    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [BIT_NUMBER-1:0] address;
    logic [BIT_NUMBER-1:0] wdata;
    logic [BIT_NUMBER-1:0] rdata;
    logic                  ready;

    modport master (
        output mem_r_en, mem_w_en, address, wdata,
        input  rdata, ready
    );

    modport slave (
        input  mem_r_en, mem_w_en, address, wdata,
        output rdata, ready
    );

endinterface

// File: rtl/sram_controller.sv
// Splits each 32-bit MEM-stage access into two 16-bit asynchronous SRAM
// phases (LOW then HIGH), freezing the pipeline via ready until DONE.
module sram_controller
    import arm_pkg::*;
#(
    parameter int BIT_NUMBER      = 32,
    parameter int SRAM_ADDR_WIDTH = 18,
    parameter int ACCESS_CYCLES   = SRAM_ACCESS_CYCLES,
    parameter int BASE_ADDR       = SRAM_BASE_ADDR
) (
    input  logic                       clk,
    input  logic                       rst,
    sram_controller_if.slave           mem,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    inout  wire  [SRAM_DQ_WIDTH-1:0]   sram_dq,
    output logic                       sram_we_n,
    output logic                       sram_oe_n
);

    localparam int HW     = SRAM_DQ_WIDTH;
    localparam int CNT_W  = $clog2(ACCESS_CYCLES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYCLES - 1);

    sram_state_t                state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic                       op_write_q, op_write_d;
    logic [BIT_NUMBER-1:0]      rdata_q, rdata_d;
    logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
    logic                       we_n_q, we_n_d;
    logic                       oe_n_q, oe_n_d;
    logic                       dq_oe_q, dq_oe_d;
    logic [HW-1:0]              dq_out_q, dq_out_d;

    logic                       req;
    logic                       phase_active;
    logic [BIT_NUMBER-1:0]      addr_offset;
    logic [SRAM_ADDR_WIDTH-2:0] word_index;
    logic                       unused_addr_bits;

    assign req         = mem.mem_r_en | mem.mem_w_en;
    assign addr_offset = mem.address - BIT_NUMBER'(BASE_ADDR);
    assign word_index  = addr_offset[2 +: SRAM_ADDR_WIDTH-1];
    assign unused_addr_bits = ^{addr_offset[BIT_NUMBER-1:SRAM_ADDR_WIDTH+1],
                                addr_offset[1:0]};

    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_write_d = op_write_q;
        rdata_d    = rdata_q;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d    = LOW;
                    cnt_d      = '0;
                    op_write_d = mem.mem_w_en;
                end
            end
            LOW: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                    if (!op_write_q) rdata_d[HW-1:0] = sram_dq;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (!op_write_q) rdata_d[2*HW-1:HW] = sram_dq;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Bus outputs are derived from the next state so they are registered
        // and line up with the phase they belong to.
        phase_active = (state_d == LOW) || (state_d == HIGH);
        sram_addr_d  = phase_active ? {word_index, state_d == HIGH} : '0;
        we_n_d       = !(phase_active && op_write_d && (cnt_d != LAST_CNT));
        oe_n_d       = !(phase_active && !op_write_d);
        dq_oe_d      = phase_active && op_write_d;
        dq_out_d     = (state_d == HIGH) ? mem.wdata[2*HW-1:HW] : mem.wdata[HW-1:0];
    end

    // NOTE: state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous here; it only takes effect on a rising clk edge.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            rdata_q     <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // ready is the only combinational output: it must drop in the same cycle
    // the request appears so the pipeline freezes immediately.
    assign mem.ready = (state_q == DONE) || ((state_q == IDLE) && !req);
    assign mem.rdata = rdata_q;
    assign sram_addr = sram_addr_q;
    assign sram_we_n = we_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_dq   = dq_oe_q ? dq_out_q : {HW{1'bz}};

endmodule
